// File: rtl/cascade_counter.sv
// -----------------------------------------------------------------------------
// cascade_counter
//
// Two-stage cascaded counter on a single clock. Stage A is a programmable-modulo
// up counter (0..A_MAX). Stage B is an up/down counter that steps once per
// stage-A terminal count. Stage A drives stage B through a clock-enable, not
// through a derived clock.
//
// Optional feature (compile-time macro):
//   CASCADE_CNT_SAT_EN  defined   -> B saturates at all 1s (up) / 0 (down), and
//                                    b_wrap pulses on every step attempted while
//                                    B is saturated.
//                       undefined -> B wraps modulo 2**WIDTH_B.
//
// Ports:
//   i_clk        in   1        single clock, all state updates on posedge
//   i_reset      in   1        synchronous, active-high
//   i_en         in   1        count enable for the whole cascade
//   i_load       in   1        synchronous load: A <= 0, B <= i_b_load_val
//   i_b_load_val in   WIDTH_B  value loaded into B on load
//   i_b_up       in   1        B direction: 1 = up, 0 = down
//   o_a_cnt      out  WIDTH_A  stage A count (registered)
//   o_b_cnt      out  WIDTH_B  stage B count (registered)
//   o_a_tc       out  1        combinational terminal count of stage A
//   o_b_wrap     out  1        registered 1-cycle pulse: B wrapped/saturated
// -----------------------------------------------------------------------------
module cascade_counter #(
    parameter int unsigned        WIDTH_A = 4,
    parameter int unsigned        WIDTH_B = 4,
    parameter int unsigned        A_MAX   = 15,
    parameter logic [WIDTH_B-1:0] B_RST   = {WIDTH_B{1'b1}}
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [WIDTH_B-1:0] i_b_load_val,
    input  logic               i_b_up,
    output logic [WIDTH_A-1:0] o_a_cnt,
    output logic [WIDTH_B-1:0] o_b_cnt,
    output logic               o_a_tc,
    output logic               o_b_wrap
);

    localparam logic [WIDTH_A-1:0] AMaxVal = WIDTH_A'(A_MAX);
    localparam logic [WIDTH_A-1:0] AOne    = WIDTH_A'(1);
    localparam logic [WIDTH_B-1:0] BOne    = WIDTH_B'(1);

    logic [WIDTH_A-1:0] r_a_cnt;
    logic [WIDTH_B-1:0] r_b_cnt;
    logic               r_b_wrap;

    logic [WIDTH_A-1:0] w_a_nxt;
    logic [WIDTH_B-1:0] w_b_nxt;
    logic               w_b_wrap_nxt;
    logic               w_a_at_max;
    logic               w_a_tc;
    logic               w_b_all1;
    logic               w_b_zero;

    // Out-of-range A values (A_MAX changed illegally) never match here, so A
    // runs on to all 1s and wraps naturally without a terminal count.
    assign w_a_at_max = (r_a_cnt == AMaxVal);
    assign w_a_tc     = i_en & w_a_at_max & ~i_load & ~i_reset;
    assign w_b_all1   = &r_b_cnt;
    assign w_b_zero   = ~|r_b_cnt;

    always_comb begin
        w_a_nxt      = r_a_cnt;
        w_b_nxt      = r_b_cnt;
        w_b_wrap_nxt = 1'b0;
        if (i_load) begin
            w_a_nxt = '0;
            w_b_nxt = i_b_load_val;
        end else if (i_en) begin
            if (w_a_at_max) begin
                // B steps on the same edge that A rolls over.
                w_a_nxt = '0;
                if (i_b_up) begin
                    w_b_wrap_nxt = w_b_all1;
`ifdef CASCADE_CNT_SAT_EN
                    if (!w_b_all1) begin
                        w_b_nxt = r_b_cnt + BOne;
                    end
`else
                    w_b_nxt = r_b_cnt + BOne;
`endif
                end else begin
                    w_b_wrap_nxt = w_b_zero;
`ifdef CASCADE_CNT_SAT_EN
                    if (!w_b_zero) begin
                        w_b_nxt = r_b_cnt - BOne;
                    end
`else
                    w_b_nxt = r_b_cnt - BOne;
`endif
                end
            end else begin
                w_a_nxt = r_a_cnt + AOne;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a_cnt  <= '0;
            r_b_cnt  <= B_RST;
            r_b_wrap <= 1'b0;
        end else begin
            r_a_cnt  <= w_a_nxt;
            r_b_cnt  <= w_b_nxt;
            r_b_wrap <= w_b_wrap_nxt;
        end
    end

    assign o_a_cnt  = r_a_cnt;
    assign o_b_cnt  = r_b_cnt;
    assign o_a_tc   = w_a_tc;
    assign o_b_wrap = r_b_wrap;

endmodule

// File: tb/tb_cascade_counter.sv
// -----------------------------------------------------------------------------
// tb_cascade_counter
//
// Scoreboard bench for cascade_counter with default parameters. The driver
// applies one input vector per cycle shortly after the rising edge and pushes
// the expected visible state for that cycle (current counts, b_wrap, and the
// combinational a_tc for the applied inputs) into a queue. Selected cycles
// also carry hand-computed expected values. The monitor pops and compares on
// every falling edge.
// -----------------------------------------------------------------------------
module tb_cascade_counter;

    logic       clk;
    logic       i_reset;
    logic       i_en;
    logic       i_load;
    logic [3:0] i_b_load_val;
    logic       i_b_up;
    logic [3:0] o_a_cnt;
    logic [3:0] o_b_cnt;
    logic       o_a_tc;
    logic       o_b_wrap;

    cascade_counter #(
        .WIDTH_A(4),
        .WIDTH_B(4),
        .A_MAX  (15),
        .B_RST  (4'hF)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_en        (i_en),
        .i_load      (i_load),
        .i_b_load_val(i_b_load_val),
        .i_b_up      (i_b_up),
        .o_a_cnt     (o_a_cnt),
        .o_b_cnt     (o_b_cnt),
        .o_a_tc      (o_a_tc),
        .o_b_wrap    (o_b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CASCADE_CNT_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    typedef struct {
        int    a;
        int    b;
        int    w;
        int    tc;
        bit    hv;
        int    ha;
        int    hb;
        int    hw;
        int    htc;
        string nm;
    } exp_t;

    exp_t scb[$];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state (value visible after the last edge).
    int ma = 0;
    int mb = 0;
    int mw = 0;
    bit mvalid = 1'b0;

    // Pending hand-computed expectation for the next cycle.
    bit    hv  = 1'b0;
    int    ha  = 0;
    int    hb  = 0;
    int    hw  = 0;
    int    htc = 0;
    string hnm = "";

    task automatic hand(input string nm, input int a, input int b, input int w, input int tc);
        hv  = 1'b1;
        hnm = nm;
        ha  = a;
        hb  = b;
        hw  = w;
        htc = tc;
    endtask

    task automatic cyc(input bit rst, input bit ld, input int bv, input bit en, input bit up);
        exp_t e;
        @(posedge clk);
        #2;
        i_reset      = rst;
        i_load       = ld;
        i_b_load_val = 4'(bv);
        i_en         = en;
        i_b_up       = up;
        if (mvalid) begin
            e.a   = ma;
            e.b   = mb;
            e.w   = mw;
            e.tc  = (en && !ld && !rst && ma == 15) ? 1 : 0;
            e.hv  = hv;
            e.ha  = ha;
            e.hb  = hb;
            e.hw  = hw;
            e.htc = htc;
            e.nm  = hnm;
            scb.push_back(e);
        end
        hv = 1'b0;
        // Advance the model across the coming edge.
        if (rst) begin
            ma = 0; mb = 15; mw = 0; mvalid = 1'b1;
        end else if (ld) begin
            ma = 0; mb = bv % 16; mw = 0;
        end else if (en) begin
            if (ma == 15) begin
                ma = 0;
                if (up) begin
                    mw = (mb == 15) ? 1 : 0;
                    mb = (Sat && mb == 15) ? 15 : (mb + 1) % 16;
                end else begin
                    mw = (mb == 0) ? 1 : 0;
                    mb = (Sat && mb == 0) ? 0 : (mb + 15) % 16;
                end
            end else begin
                ma = ma + 1;
                mw = 0;
            end
        end else begin
            mw = 0;
        end
    endtask

    task automatic cmp(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one scoreboard entry per presented cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                cmp("a_cnt", int'(o_a_cnt), e.a);
                cmp("b_cnt", int'(o_b_cnt), e.b);
                cmp("b_wrap", int'(o_b_wrap), e.w);
                cmp("a_tc", int'(o_a_tc), e.tc);
                if (e.hv) begin
                    cmp({e.nm, ".a_cnt"}, int'(o_a_cnt), e.ha);
                    cmp({e.nm, ".b_cnt"}, int'(o_b_cnt), e.hb);
                    cmp({e.nm, ".b_wrap"}, int'(o_b_wrap), e.hw);
                    cmp({e.nm, ".a_tc"}, int'(o_a_tc), e.htc);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset      = 1'b1;
        i_load       = 1'b0;
        i_b_load_val = 4'h0;
        i_en         = 1'b0;
        i_b_up       = 1'b0;

        // Reset for two cycles.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Count down through a full B cycle and stop with A at 7.
        for (int i = 0; i < 263; i++) begin
            if (i == 0)   hand("reset_state", 0, 15, 0, 0);
            if (i == 15)  hand("first_tc", 15, 15, 0, 1);
            if (i == 16)  hand("b_f_to_e", 0, 14, 0, 0);
            if (i == 240) hand("b_at_zero", 0, 0, 0, 0);
            if (i == 256) hand("b_wrap_0_to_f", 0, 15, 1, 0);
            if (i == 257) hand("b_wrap_clears", 1, 15, 0, 0);
            cyc(0, 0, 0, 1, 0);
        end

        // Freeze at A = 7.
        for (int i = 0; i < 5; i++) begin
            hand("freeze", 7, 15, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        hand("resume_at_7", 7, 15, 0, 0);
        cyc(0, 0, 0, 1, 0);
        hand("resume_to_8", 8, 15, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);

        // Load at the terminal count suppresses a_tc and the B step.
        hand("load_at_tc", 15, 15, 0, 0);
        cyc(0, 1, 3, 1, 0);
        hand("after_load", 0, 3, 0, 0);
        cyc(0, 1, 14, 1, 1);

        // Count up from E across the top of B.
        for (int j = 0; j < 34; j++) begin
            if (j == 0)  hand("up_start", 0, 14, 0, 0);
            if (j == 15) hand("up_tc", 15, 14, 0, 1);
            if (j == 16) hand("up_e_to_f", 0, 15, 0, 0);
            if (j == 32) hand("up_top_step", 0, Sat ? 15 : 0, 1, 0);
            if (j == 33) hand("up_wrap_clears", 1, Sat ? 15 : 0, 0, 0);
            cyc(0, 0, 0, 1, 1);
        end

        // Reset wins over a simultaneous load.
        cyc(0, 1, 5, 1, 0);
        for (int k = 0; k < 9; k++) cyc(0, 0, 0, 1, 0);
        hand("reset_and_load", 9, 5, 0, 0);
        cyc(1, 1, 10, 1, 0);
        hand("after_reset_load", 0, 15, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Down step from B = 0.
        cyc(0, 1, 0, 0, 0);
        for (int m = 0; m < 16; m++) begin
            if (m == 15) hand("down_tc_at_zero", 15, 0, 0, 1);
            cyc(0, 0, 0, 1, 0);
        end
        hand("down_bottom_step", 0, Sat ? 0 : 15, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset held high while A sits at the terminal value: a_tc stays low.
        for (int m = 0; m < 15; m++) cyc(0, 0, 0, 1, 0);
        hand("tc_masked_by_reset", 15, Sat ? 0 : 15, 0, 0);
        cyc(1, 0, 0, 1, 0);
        hand("after_reset_tc", 0, 15, 0, 0);
        cyc(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_chk++;
        if (scb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", scb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
